// File: rtl/dot_operand_pingpong_buffer.sv
// dot_operand_pingpong_buffer: two-bank operand store; one bank fills while the other streams to the MAC.
module dot_operand_pingpong_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH = 2,
  parameter int VEC_LEN = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
  output logic [IDX_WIDTH-1:0]         rd_index,
  output logic                         rd_last,
  output logic [1:0]                   banks_full
);
  localparam int W = NUM_CH * DATA_WIDTH;
  localparam logic [IDX_WIDTH-1:0] last_idx = IDX_WIDTH'(VEC_LEN - 1);
  logic [W-1:0] mem [2][VEC_LEN];
  logic [1:0] full;
  logic wbank, rbank;
  logic [IDX_WIDTH-1:0] widx, ridx;
  logic wr_fire, rd_fire;
  always_comb begin
    wr_ready = !full[wbank] && !flush;
    rd_valid = full[rbank] && !flush;
    rd_data = mem[rbank][ridx];
    rd_index = ridx;
    rd_last = rd_valid && (ridx == last_idx);
    banks_full = {1'b0, full[0]} + {1'b0, full[1]};
    wr_fire = wr_valid && wr_ready;
    rd_fire = rd_valid && rd_ready;
  end
  // write only targets an empty bank and read only a full one, so the two full-bit updates never collide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
      wbank <= 1'b0;
      rbank <= 1'b0;
      widx <= '0;
      ridx <= '0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < VEC_LEN; i++)
          mem[b][i] <= '0;
    end else if (flush) begin
      full <= '0;
      wbank <= 1'b0;
      rbank <= 1'b0;
      widx <= '0;
      ridx <= '0;
    end else begin
      if (wr_fire) begin
        mem[wbank][widx] <= wr_data;
        widx <= (widx == last_idx) ? '0 : widx + 1'b1;
        if (widx == last_idx) begin
          full[wbank] <= 1'b1;
          wbank <= !wbank;
        end
      end
      if (rd_fire) begin
        ridx <= (ridx == last_idx) ? '0 : ridx + 1'b1;
        if (ridx == last_idx) begin
          full[rbank] <= 1'b0;
          rbank <= !rbank;
        end
      end
    end
  end
endmodule

// File: tb/tb_dot_operand_pingpong_buffer.sv
// tb_dot_operand_pingpong_buffer: scenario tasks checked against a queue-based model of completed vectors.
module tb_dot_operand_pingpong_buffer;
  localparam int DW = 8, NC = 2, VL = 4, IW = 2, W = DW * NC;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, wr_valid = 1'b0, rd_ready = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic wr_ready, rd_valid, rd_last;
  logic [W-1:0] rd_data;
  logic [IW-1:0] rd_index;
  logic [1:0] banks_full;
  int n_cmp = 0, n_bad = 0;
  logic [W-1:0] part[$];
  logic [W-1:0] done[$];
  int nfull = 0, pos = 0;

  dot_operand_pingpong_buffer #(.DATA_WIDTH(DW), .NUM_CH(NC), .VEC_LEN(VL), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_index(rd_index), .rd_last(rd_last), .banks_full(banks_full));

  always #5 clk = ~clk;

  function automatic logic m_wr_ready(); return nfull < 2 && !flush; endfunction
  function automatic logic m_rd_valid(); return nfull > 0 && !flush; endfunction
  function automatic logic [W-1:0] m_rd_data(); return done.size() > 0 ? done[0] : '0; endfunction
  function automatic logic [W-1:0] pack(int a, int b); return {DW'(b), DW'(a)}; endfunction

  task automatic model_clear();
    part.delete();
    done.delete();
    nfull = 0;
    pos = 0;
  endtask

  task automatic tick();
    logic fw, fr;
    fw = wr_valid && m_wr_ready();
    fr = rd_ready && m_rd_valid();
    @(posedge clk);
    if (!rst_n || flush) model_clear();
    else begin
      if (fr) begin
        void'(done.pop_front());
        pos++;
        if (pos == VL) begin pos = 0; nfull--; end
      end
      if (fw) begin
        part.push_back(wr_data);
        if (part.size() == VL) begin
          foreach (part[i]) done.push_back(part[i]);
          part.delete();
          nfull++;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    wr_valid = 0; rd_ready = 0; flush = 0; rst_n = 0;
    #1;
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    logic [W-1:0] first;
    #1;
    n_cmp++; if (wr_ready !== 1'b1 || rd_valid !== 1'b0 || banks_full !== 2'd0) begin n_bad++; $display("FAIL reset_init got wr_ready=%b rd_valid=%b banks_full=%0d want 1 0 0", wr_ready, rd_valid, banks_full); end
    @(posedge clk); #1;
    rst_n = 1;
    model_clear();
    for (int i = 0; i < 2; i++) begin wr_valid = 1; wr_data = W'($urandom); tick(); end
    wr_valid = 0; rst_n = 0;
    #1;
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    n_cmp++; if (rd_data !== '0) begin n_bad++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    n_cmp++; if (rd_index !== '0) begin n_bad++; $display("FAIL reset_rd_index got %0d want 0", rd_index); end
    n_cmp++; if (rd_last !== 1'b0) begin n_bad++; $display("FAIL reset_rd_last got %b want 0", rd_last); end
    n_cmp++; if (banks_full !== 2'd0) begin n_bad++; $display("FAIL reset_banks_full got %0d want 0", banks_full); end
    tick();
    rst_n = 1;
    model_clear();
    #1;
    n_cmp++; if (wr_ready !== 1'b1 || rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_release got wr_ready=%b rd_valid=%b want 1 0", wr_ready, rd_valid); end
    first = W'($urandom);
    for (int i = 0; i < VL; i++) begin wr_valid = 1; wr_data = (i == 0) ? first : W'($urandom); tick(); end
    wr_valid = 0;
    #1;
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== first) begin n_bad++; $display("FAIL reset_discard got valid=%b data=%h want 1 %h", rd_valid, rd_data, first); end
  endtask

  task automatic test_single();
    do_reset();
    rd_ready = 1;
    for (int i = 0; i < VL; i++) begin
      wr_valid = 1; wr_data = pack(i + 1, i + 5);
      #1;
      n_cmp++; if (wr_ready !== 1'b1 || rd_valid !== 1'b0) begin n_bad++; $display("FAIL single_write%0d got wr_ready=%b rd_valid=%b want 1 0", i, wr_ready, rd_valid); end
      tick();
    end
    wr_valid = 0;
    for (int i = 0; i < VL; i++) begin
      #1;
      n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid%0d got %b want 1", i, rd_valid); end
      n_cmp++; if (rd_data !== pack(i + 1, i + 5)) begin n_bad++; $display("FAIL single_data%0d got %h want %h", i, rd_data, pack(i + 1, i + 5)); end
      n_cmp++; if (rd_index !== IW'(i)) begin n_bad++; $display("FAIL single_index%0d got %0d want %0d", i, rd_index, i); end
      n_cmp++; if (rd_last !== (i == VL - 1)) begin n_bad++; $display("FAIL single_last%0d got %b want %b", i, rd_last, i == VL - 1); end
      tick();
    end
    #1;
    n_cmp++; if (rd_valid !== 1'b0 || banks_full !== 2'd0) begin n_bad++; $display("FAIL single_empty got rd_valid=%b banks_full=%0d want 0 0", rd_valid, banks_full); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] vals[8];
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1; vals[i] = W'($urandom); wr_data = vals[i];
      #1;
      n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL bp_fill%0d got wr_ready=%b want 1", i, wr_ready); end
      tick();
    end
    wr_data = W'($urandom);
    #1;
    n_cmp++; if (banks_full !== 2'd2 || wr_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full got banks_full=%0d wr_ready=%b want 2 0", banks_full, wr_ready); end
    tick(); tick();
    rd_ready = 1;
    for (int i = 0; i < VL; i++) begin
      #1;
      n_cmp++; if (wr_ready !== 1'b0 || rd_data !== vals[i]) begin n_bad++; $display("FAIL bp_drain%0d got wr_ready=%b data=%h want 0 %h", i, wr_ready, rd_data, vals[i]); end
      tick();
    end
    rd_ready = 0;
    #1;
    n_cmp++; if (wr_ready !== 1'b1 || banks_full !== 2'd1) begin n_bad++; $display("FAIL bp_release got wr_ready=%b banks_full=%0d want 1 1", wr_ready, banks_full); end
    tick();
    wr_valid = 0;
    #1;
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== vals[4] || rd_index !== '0) begin n_bad++; $display("FAIL bp_bank1 got valid=%b data=%h idx=%0d want 1 %h 0", rd_valid, rd_data, rd_index, vals[4]); end
  endtask

  task automatic test_read_stall();
    logic [W-1:0] vals[VL];
    int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
    int k = 0;
    do_reset();
    for (int i = 0; i < VL; i++) begin wr_valid = 1; vals[i] = W'($urandom); wr_data = vals[i]; tick(); end
    wr_valid = 0;
    for (int c = 0; c < 7; c++) begin
      rd_ready = pat[c][0];
      #1;
      n_cmp++; if (rd_valid !== 1'b1 || rd_data !== vals[k] || rd_index !== IW'(k)) begin n_bad++; $display("FAIL stall_c%0d got valid=%b data=%h idx=%0d want 1 %h %0d", c, rd_valid, rd_data, rd_index, vals[k], k); end
      n_cmp++; if (rd_last !== (k == VL - 1)) begin n_bad++; $display("FAIL stall_last_c%0d got %b want %b", c, rd_last, k == VL - 1); end
      if (pat[c] != 0) k++;
      tick();
    end
    rd_ready = 0;
    #1;
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL stall_end got rd_valid=%b want 0", rd_valid); end
  endtask

  task automatic test_stream();
    int rcnt = 0;
    do_reset();
    rd_ready = 1;
    for (int c = 0; c < 44; c++) begin
      wr_valid = c < 40; wr_data = W'(c);
      #1;
      n_cmp++; if (banks_full > 2'd1) begin n_bad++; $display("FAIL stream_bf_c%0d got %0d want <=1", c, banks_full); end
      if (c < 40) begin n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL stream_wr_ready_c%0d got %b want 1", c, wr_ready); end end
      n_cmp++; if (rd_valid !== (c >= 4)) begin n_bad++; $display("FAIL stream_valid_c%0d got %b want %b", c, rd_valid, c >= 4); end
      if (c >= 4) begin
        n_cmp++; if (rd_data !== W'(rcnt) || rd_index !== IW'(rcnt % VL) || rd_last !== (rcnt % VL == VL - 1)) begin n_bad++; $display("FAIL stream_beat%0d got data=%h idx=%0d last=%b want %h %0d %b", rcnt, rd_data, rd_index, rd_last, W'(rcnt), rcnt % VL, rcnt % VL == VL - 1); end
        rcnt++;
      end
      tick();
    end
    wr_valid = 0; rd_ready = 0;
    #1;
    n_cmp++; if (rd_valid !== 1'b0 || banks_full !== 2'd0) begin n_bad++; $display("FAIL stream_end got rd_valid=%b banks_full=%0d want 0 0", rd_valid, banks_full); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < VL + 2; i++) begin wr_valid = 1; wr_data = W'($urandom); tick(); end
    flush = 1;
    #1;
    n_cmp++; if (wr_ready !== 1'b0 || rd_valid !== 1'b0) begin n_bad++; $display("FAIL flush_mask got wr_ready=%b rd_valid=%b want 0 0", wr_ready, rd_valid); end
    tick();
    flush = 0; wr_valid = 0;
    #1;
    n_cmp++; if (banks_full !== 2'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b1) begin n_bad++; $display("FAIL flush_clear got banks_full=%0d rd_valid=%b wr_ready=%b want 0 0 1", banks_full, rd_valid, wr_ready); end
    for (int i = 0; i < VL; i++) begin wr_valid = 1; wr_data = pack(30 + i, 40 + i); tick(); end
    wr_valid = 0; rd_ready = 1;
    for (int i = 0; i < VL; i++) begin
      #1;
      n_cmp++; if (rd_valid !== 1'b1 || rd_data !== pack(30 + i, 40 + i) || rd_index !== IW'(i)) begin n_bad++; $display("FAIL flush_read%0d got valid=%b data=%h idx=%0d want 1 %h %0d", i, rd_valid, rd_data, rd_index, pack(30 + i, 40 + i), i); end
      tick();
    end
    rd_ready = 0;
    #1;
    n_cmp++; if (rd_valid !== 1'b0 || banks_full !== 2'd0) begin n_bad++; $display("FAIL flush_end got rd_valid=%b banks_full=%0d want 0 0", rd_valid, banks_full); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      wr_valid = 1'($urandom_range(0, 1));
      rd_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 39) == 0;
      wr_data = W'($urandom);
      #1;
      n_cmp++; if (wr_ready !== m_wr_ready() || rd_valid !== m_rd_valid()) begin n_bad++; $display("FAIL rand_hs_c%0d got wr_ready=%b rd_valid=%b want %b %b", c, wr_ready, rd_valid, m_wr_ready(), m_rd_valid()); end
      n_cmp++; if (banks_full !== 2'(nfull)) begin n_bad++; $display("FAIL rand_bf_c%0d got %0d want %0d", c, banks_full, nfull); end
      n_cmp++; if (rd_last !== (m_rd_valid() && pos == VL - 1)) begin n_bad++; $display("FAIL rand_last_c%0d got %b want %b", c, rd_last, m_rd_valid() && pos == VL - 1); end
      if (m_rd_valid()) begin
        n_cmp++; if (rd_data !== m_rd_data() || rd_index !== IW'(pos)) begin n_bad++; $display("FAIL rand_data_c%0d got %h idx=%0d want %h %0d", c, rd_data, rd_index, m_rd_data(), pos); end
      end
      tick();
    end
    flush = 0; wr_valid = 0; rd_ready = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_read_stall();
    test_stream();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
